// File: rtl/dcache_fifo_fill_pkg.sv
// Shared definitions for the dcache fill FIFO block.
// Holds the set/tag geometry, FIFO dimensions, the entry layout
// {index, tag, data}, the controller state enum and the per-line
// operation codes used between the controller and each FIFO line.
package dcache_fifo_fill_pkg;

    localparam int NUM_SET_BITS           = 5;
    localparam int NUM_TAG_BITS           = 8;
    localparam int NUM_FIFO               = 4;
    localparam int FIFO_SIZE              = 4;
    localparam int NUM_FIFO_BITS          = $clog2(NUM_FIFO);
    localparam int NUM_FIFO_SIZE_BITS     = $clog2(FIFO_SIZE);
    localparam int DCACHE_FIFO_ENTRY_BITS = NUM_SET_BITS + NUM_TAG_BITS + 64;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } fill_state_e;

    // What a single FIFO line does on the next clock edge.
    typedef enum logic [2:0] {
        LN_HOLD   = 3'd0,
        LN_UPDATE = 3'd1,   // overwrite data of one slot in place
        LN_SHIFT  = 3'd2,   // push new entry into slot 0, drop the last slot
        LN_LOAD   = 3'd3,   // clear, bind, write new entry into slot 0
        LN_CLEAR  = 3'd4    // clear entries, valids and binding
    } line_op_e;

    typedef struct packed {
        logic [NUM_SET_BITS-1:0] index;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } fifo_entry_t;

endpackage

// File: rtl/dcache_fifo_line.sv
// One fill FIFO: FIFO_SIZE entries, per-entry valids and a bound flag.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   op                - operation to apply at the next rising edge
//   upd_slot          - slot whose data is overwritten for LN_UPDATE
//   wr_entry          - entry written for LN_UPDATE/LN_SHIFT/LN_LOAD
//   entries/valid     - registered contents, slot 0 is the newest
//   bound             - registered "this line owns a set index" flag
module dcache_fifo_line #(
    parameter int FIFO_SIZE = dcache_fifo_fill_pkg::FIFO_SIZE,
    parameter int SLOT_W    = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  dcache_fifo_fill_pkg::line_op_e                   op,
    input  logic [SLOT_W-1:0]                                upd_slot,
    input  dcache_fifo_fill_pkg::fifo_entry_t                wr_entry,
    output dcache_fifo_fill_pkg::fifo_entry_t [FIFO_SIZE-1:0] entries,
    output logic [FIFO_SIZE-1:0]                             valid,
    output logic                                             bound
);
    import dcache_fifo_fill_pkg::*;

    fifo_entry_t [FIFO_SIZE-1:0] entries_q, entries_d;
    logic [FIFO_SIZE-1:0]        valid_q, valid_d;
    logic                        bound_q, bound_d;

    assign entries = entries_q;
    assign valid   = valid_q;
    assign bound   = bound_q;

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        bound_d   = bound_q;
        case (op)
            LN_UPDATE: entries_d[upd_slot].data = wr_entry.data;
            LN_SHIFT: begin
                // Zeros shift in behind the last valid entry, so invalid
                // slots stay all-zero and valids stay contiguous.
                for (int k = FIFO_SIZE - 1; k > 0; k--) begin
                    entries_d[k] = entries_q[k-1];
                    valid_d[k]   = valid_q[k-1];
                end
                entries_d[0] = wr_entry;
                valid_d[0]   = 1'b1;
            end
            LN_LOAD: begin
                entries_d    = '0;
                valid_d      = '0;
                entries_d[0] = wr_entry;
                valid_d[0]   = 1'b1;
                bound_d      = 1'b1;
            end
            LN_CLEAR: begin
                entries_d = '0;
                valid_d   = '0;
                bound_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entries_q <= '0;
            valid_q   <= '0;
            bound_q   <= 1'b0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            bound_q   <= bound_d;
        end
    end

endmodule

// File: rtl/dcache_fifo_fill.sv
// Data-cache fill buffer: NUM_FIFO per-set FIFOs of FIFO_SIZE entries.
// A fill updates a matching tag in place, otherwise shifts into the FIFO
// bound to its set, otherwise binds a free FIFO or evicts one round-robin.
// A flush clears one FIFO per cycle and pulses flush_done when finished.
// Ports:
//   clock, reset                  - clock, synchronous active-high reset
//   fill_valid/fill_ready         - fill handshake
//   fill_index/fill_tag/fill_data - the fill line
//   flush_req/flush_done          - flush request and completion pulse
//   FIFO, entry_valid, fifo_bound - registered FIFO contents and status
module dcache_fifo_fill #(
    parameter int NUM_FIFO  = dcache_fifo_fill_pkg::NUM_FIFO,
    parameter int FIFO_SIZE = dcache_fifo_fill_pkg::FIFO_SIZE
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          fill_valid,
    output logic                                          fill_ready,
    input  logic [dcache_fifo_fill_pkg::NUM_SET_BITS-1:0] fill_index,
    input  logic [dcache_fifo_fill_pkg::NUM_TAG_BITS-1:0] fill_tag,
    input  logic [63:0]                                   fill_data,
    input  logic                                          flush_req,
    output logic                                          flush_done,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0][dcache_fifo_fill_pkg::DCACHE_FIFO_ENTRY_BITS-1:0] FIFO,
    output logic [NUM_FIFO-1:0][FIFO_SIZE-1:0]            entry_valid,
    output logic [NUM_FIFO-1:0]                           fifo_bound
);
    import dcache_fifo_fill_pkg::*;

    localparam int PTR_W  = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
    localparam int SLOT_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;

    fill_state_e                           state_q, state_d;
    logic [PTR_W-1:0]                      flush_cnt_q, flush_cnt_d;
    logic [PTR_W-1:0]                      victim_q, victim_d;
    logic                                  flush_done_q, flush_done_d;

    fifo_entry_t [NUM_FIFO-1:0][FIFO_SIZE-1:0] line_ent;
    line_op_e                              line_op [NUM_FIFO];
    fifo_entry_t                           wr_entry;
    logic [SLOT_W-1:0]                     upd_slot;
    logic                                  idx_hit, tag_hit, free_any;
    logic [PTR_W-1:0]                      hit_fifo, free_fifo;

    assign wr_entry   = '{index: fill_index, tag: fill_tag, data: fill_data};
    assign fill_ready = (state_q == IDLE) && !flush_req;
    assign flush_done = flush_done_q;
    assign FIFO       = line_ent;

    // Lookup. A bound FIFO stores only its own set index, so slot 0 names
    // the set; at most one FIFO can match and tags within it are unique.
    always_comb begin
        idx_hit   = 1'b0;
        tag_hit   = 1'b0;
        hit_fifo  = '0;
        upd_slot  = '0;
        free_any  = 1'b0;
        free_fifo = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (fifo_bound[i] && line_ent[i][0].index == fill_index) begin
                idx_hit  = 1'b1;
                hit_fifo = PTR_W'(i);
                for (int k = 0; k < FIFO_SIZE; k++) begin
                    if (entry_valid[i][k] && line_ent[i][k].tag == fill_tag) begin
                        tag_hit  = 1'b1;
                        upd_slot = SLOT_W'(k);
                    end
                end
            end
        end
        // Descending scan leaves the lowest-numbered free FIFO selected.
        for (int i = NUM_FIFO - 1; i >= 0; i--) begin
            if (!fifo_bound[i]) begin
                free_any  = 1'b1;
                free_fifo = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        victim_d     = victim_q;
        flush_done_d = 1'b0;
        for (int i = 0; i < NUM_FIFO; i++) line_op[i] = LN_HOLD;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (fill_valid) begin
                    if (tag_hit)       line_op[hit_fifo]  = LN_UPDATE;
                    else if (idx_hit)  line_op[hit_fifo]  = LN_SHIFT;
                    else if (free_any) line_op[free_fifo] = LN_LOAD;
                    else begin
                        line_op[victim_q] = LN_LOAD;
                        victim_d = (victim_q == PTR_W'(NUM_FIFO - 1)) ? '0 : victim_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                line_op[flush_cnt_q] = LN_CLEAR;
                if (flush_cnt_q == PTR_W'(NUM_FIFO - 1)) begin
                    state_d      = IDLE;
                    flush_cnt_d  = '0;
                    victim_d     = '0;
                    flush_done_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            victim_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            victim_q     <= victim_d;
            flush_done_q <= flush_done_d;
        end
    end

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_line
        dcache_fifo_line #(
            .FIFO_SIZE (FIFO_SIZE),
            .SLOT_W    (SLOT_W)
        ) u_line (
            .clock    (clock),
            .reset    (reset),
            .op       (line_op[g]),
            .upd_slot (upd_slot),
            .wr_entry (wr_entry),
            .entries  (line_ent[g]),
            .valid    (entry_valid[g]),
            .bound    (fifo_bound[g])
        );
    end

endmodule

// File: tb/tb_dcache_fifo_fill.sv
// Bench for dcache_fifo_fill: directed scenarios plus a randomized run
// checked against a queue-style reference model of the fill rules.
module tb_dcache_fifo_fill;
    import dcache_fifo_fill_pkg::*;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int EB = DCACHE_FIFO_ENTRY_BITS;

    logic clock = 1'b0;
    logic reset, fill_valid, fill_ready, flush_req, flush_done;
    logic [NUM_SET_BITS-1:0] fill_index;
    logic [NUM_TAG_BITS-1:0] fill_tag;
    logic [63:0]             fill_data;
    logic [N-1:0][S-1:0][EB-1:0] fifo_o;
    logic [N-1:0][S-1:0]         ev;
    logic [N-1:0]                bound;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per FIFO a bound flag, its set and a list of
    // (tag, data) pairs, newest first.
    logic                    m_bound [N];
    logic [NUM_SET_BITS-1:0] m_idx   [N];
    logic [NUM_TAG_BITS-1:0] m_tag   [N][S];
    logic [63:0]             m_data  [N][S];
    int                      m_cnt   [N];
    int                      m_victim;

    dcache_fifo_fill #(.NUM_FIFO(N), .FIFO_SIZE(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .FIFO        (fifo_o),
        .entry_valid (ev),
        .fifo_bound  (bound)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; fill_valid = 1'b0; flush_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic do_fill(input int idx, input int tag, input logic [63:0] data);
        fill_valid = 1'b1;
        fill_index = NUM_SET_BITS'(idx);
        fill_tag   = NUM_TAG_BITS'(tag);
        fill_data  = data;
        step();
        fill_valid = 1'b0;
    endtask

    function automatic fifo_entry_t mk(input int idx, input int tag, input logic [63:0] data);
        mk = '{index: NUM_SET_BITS'(idx), tag: NUM_TAG_BITS'(tag), data: data};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_bound[i] = 1'b0; m_idx[i] = '0; m_cnt[i] = 0;
        end
        m_victim = 0;
    endfunction

    function automatic void model_fill(input logic [NUM_SET_BITS-1:0] idx,
                                       input logic [NUM_TAG_BITS-1:0] tag,
                                       input logic [63:0] data);
        int f, slot;
        f = -1;
        for (int i = 0; i < N; i++) if (m_bound[i] && m_idx[i] == idx) f = i;
        if (f >= 0) begin
            slot = -1;
            for (int k = 0; k < m_cnt[f]; k++) if (m_tag[f][k] == tag) slot = k;
            if (slot >= 0) m_data[f][slot] = data;
            else begin
                for (int k = S - 1; k > 0; k--) begin
                    m_tag[f][k]  = m_tag[f][k-1];
                    m_data[f][k] = m_data[f][k-1];
                end
                m_tag[f][0] = tag; m_data[f][0] = data;
                if (m_cnt[f] < S) m_cnt[f]++;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) if (!m_bound[i]) f = i;
            if (f < 0) begin
                f = m_victim;
                m_victim = (m_victim + 1) % N;
            end
            m_bound[f] = 1'b1; m_idx[f] = idx; m_cnt[f] = 1;
            m_tag[f][0] = tag; m_data[f][0] = data;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; fill_valid = 1'b1; flush_req = 1'b0;
        fill_index = 5'd1; fill_tag = 8'd1; fill_data = 64'd1;
        step(); step();
        reset = 1'b0; fill_valid = 1'b0;
        #1;
        n_cmp++; if (fifo_o !== '0) begin n_fail++; $display("FAIL reset_fifo got %h want 0", fifo_o); end
        n_cmp++; if (ev !== '0) begin n_fail++; $display("FAIL reset_valid got %h want 0", ev); end
        n_cmp++; if (bound !== '0) begin n_fail++; $display("FAIL reset_bound got %b want 0", bound); end
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
        n_cmp++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fill_ready got %b want 1", fill_ready); end
    endtask

    task automatic test_first_fill();
        fifo_entry_t exp;
        apply_reset();
        do_fill(3, 'h12, 64'hAA);
        exp = mk(3, 'h12, 64'hAA);
        n_cmp++; if (fifo_o[0][0] !== exp) begin n_fail++; $display("FAIL first_entry got %h want %h", fifo_o[0][0], exp); end
        n_cmp++; if (ev !== 16'h0001) begin n_fail++; $display("FAIL first_valid got %h want 0001", ev); end
        n_cmp++; if (bound !== 4'b0001) begin n_fail++; $display("FAIL first_bound got %b want 0001", bound); end
    endtask

    task automatic test_shift();
        apply_reset();
        for (int t = 1; t <= 5; t++) do_fill(3, t, 64'h100 + 64'(t));
        for (int k = 0; k < S; k++) begin
            fifo_entry_t exp;
            exp = mk(3, 5 - k, 64'h100 + 64'(5 - k));
            n_cmp++;
            if (fifo_o[0][k] !== exp) begin
                n_fail++; $display("FAIL shift_slot%0d got %h want %h", k, fifo_o[0][k], exp);
            end
        end
        n_cmp++; if (ev[0] !== 4'hF) begin n_fail++; $display("FAIL shift_valid got %b want 1111", ev[0]); end
        n_cmp++; if (bound !== 4'b0001) begin n_fail++; $display("FAIL shift_bound got %b want 0001", bound); end
    endtask

    // Continues from test_shift: FIFO 0 holds tags 5,4,3,2.
    task automatic test_update();
        do_fill(3, 3, 64'h55);
        for (int k = 0; k < S; k++) begin
            fifo_entry_t exp;
            exp = (k == 2) ? mk(3, 3, 64'h55) : mk(3, 5 - k, 64'h100 + 64'(5 - k));
            n_cmp++;
            if (fifo_o[0][k] !== exp) begin
                n_fail++; $display("FAIL update_slot%0d got %h want %h", k, fifo_o[0][k], exp);
            end
        end
        n_cmp++; if (ev !== 16'h000F) begin n_fail++; $display("FAIL update_valid got %h want 000f", ev); end
    endtask

    task automatic test_evict();
        apply_reset();
        for (int i = 1; i <= 4; i++) do_fill(i, 'h20 + i, 64'(i));
        do_fill(7, 'h77, 64'h7777);
        n_cmp++; if (bound !== 4'hF) begin n_fail++; $display("FAIL evict_bound got %b want 1111", bound); end
        n_cmp++; if (fifo_o[0][0] !== mk(7, 'h77, 64'h7777)) begin n_fail++; $display("FAIL evict0_entry got %h want %h", fifo_o[0][0], mk(7, 'h77, 64'h7777)); end
        n_cmp++; if (ev !== 16'h1111) begin n_fail++; $display("FAIL evict0_valid got %h want 1111", ev); end
        n_cmp++; if (fifo_o[1][0] !== mk(2, 'h22, 64'd2)) begin n_fail++; $display("FAIL evict0_other got %h want %h", fifo_o[1][0], mk(2, 'h22, 64'd2)); end
        do_fill(8, 'h88, 64'h8888);
        n_cmp++; if (fifo_o[1][0] !== mk(8, 'h88, 64'h8888)) begin n_fail++; $display("FAIL evict1_entry got %h want %h", fifo_o[1][0], mk(8, 'h88, 64'h8888)); end
        n_cmp++; if (fifo_o[0][0] !== mk(7, 'h77, 64'h7777)) begin n_fail++; $display("FAIL evict1_keep0 got %h want %h", fifo_o[0][0], mk(7, 'h77, 64'h7777)); end
    endtask

    // Continues from test_evict with all FIFOs populated.
    task automatic test_flush();
        int low, pulses;
        low = 0; pulses = 0;
        flush_req = 1'b1; fill_valid = 1'b1;
        fill_index = 5'd9; fill_tag = 8'h99; fill_data = 64'h9999;
        #1;
        n_cmp++; if (fill_ready !== 1'b0) begin n_fail++; $display("FAIL flush_fill_ready got %b want 0", fill_ready); end
        step();
        flush_req = 1'b0; fill_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (flush_done === 1'b1) pulses++;
            if (fill_ready === 1'b1) break;
            low++;
            step();
        end
        n_cmp++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL flush_done_at_idle got %b want 1", flush_done); end
        step();
        if (flush_done === 1'b1) pulses++;
        n_cmp++; if (low != N) begin n_fail++; $display("FAIL flush_cycles got %0d want %0d", low, N); end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL flush_pulses got %0d want 1", pulses); end
        n_cmp++; if (fifo_o !== '0 || ev !== '0 || bound !== '0) begin
            n_fail++; $display("FAIL flush_cleared got bound %b valid %h want all 0", bound, ev);
        end
        // Victim pointer restarts at 0: fill 5 sets, the fifth evicts FIFO 0.
        for (int i = 1; i <= 5; i++) do_fill(10 + i, i, 64'(i));
        n_cmp++; if (fifo_o[0][0] !== mk(15, 5, 64'd5)) begin n_fail++; $display("FAIL flush_victim_reset got %h want %h", fifo_o[0][0], mk(15, 5, 64'd5)); end
    endtask

    task automatic test_reset_mid_flush();
        int pulses;
        pulses = 0;
        apply_reset();
        do_fill(2, 1, 64'd1);
        do_fill(5, 2, 64'd2);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL midflush_ready got %b want 1", fill_ready); end
        n_cmp++; if (fifo_o !== '0 || ev !== '0 || bound !== '0) begin
            n_fail++; $display("FAIL midflush_cleared got bound %b valid %h want all 0", bound, ev);
        end
        for (int c = 0; c < 8; c++) begin
            if (flush_done === 1'b1) pulses++;
            step();
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL midflush_done got %0d pulses want 0", pulses); end
    endtask

    task automatic test_random();
        apply_reset();
        model_clear();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic v, bad;
            v = ($urandom_range(0, 3) != 0);
            fill_valid = v;
            fill_index = NUM_SET_BITS'($urandom_range(0, 7));
            fill_tag   = NUM_TAG_BITS'($urandom_range(0, 5));
            fill_data  = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want 1", cyc, fill_ready); end
            if (v) model_fill(fill_index, fill_tag, fill_data);
            step();
            fill_valid = 1'b0;
            bad = 1'b0;
            n_cmp++;
            for (int i = 0; i < N; i++) begin
                if (!bad && bound[i] !== m_bound[i]) begin
                    bad = 1'b1;
                    $display("FAIL rand_bound cyc %0d fifo %0d got %b want %b", cyc, i, bound[i], m_bound[i]);
                end
                for (int k = 0; k < S; k++) begin
                    fifo_entry_t exp;
                    logic        vexp;
                    if (k < m_cnt[i]) begin
                        exp = '{index: m_idx[i], tag: m_tag[i][k], data: m_data[i][k]};
                        vexp = 1'b1;
                    end else begin
                        exp = '0;
                        vexp = 1'b0;
                    end
                    if (!bad && (fifo_o[i][k] !== exp || ev[i][k] !== vexp)) begin
                        bad = 1'b1;
                        $display("FAIL rand_entry cyc %0d fifo %0d slot %0d got %h/%b want %h/%b",
                                 cyc, i, k, fifo_o[i][k], ev[i][k], exp, vexp);
                    end
                end
            end
            if (bad) n_fail++;
        end
    endtask

    initial begin
        reset = 1'b1; fill_valid = 1'b0; flush_req = 1'b0;
        fill_index = '0; fill_tag = '0; fill_data = '0;
        test_reset();
        test_first_fill();
        test_shift();
        test_update();
        test_evict();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_fifo_fill.md
DCACHE_FIFO_FILL -- requirements
Module: dcache_fifo_fill

Interface
REQ-001 SHALL have parameter NUM_FIFO, default `NUM_FIFO (4): number of per-set fill FIFOs.
REQ-002 SHALL have parameter FIFO_SIZE, default `FIFO_SIZE (4): entries per FIFO.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fill_valid  input  1  a fill line is offered this cycle.
REQ-006 SHALL have port fill_ready  output  1  the fill is accepted this cycle when fill_valid is also high.
REQ-007 SHALL have port fill_index  input  `NUM_SET_BITS  set index of the fill.
REQ-008 SHALL have port fill_tag  input  `NUM_TAG_BITS  tag of the fill.
REQ-009 SHALL have port fill_data  input  64  fill data word.
REQ-010 SHALL have port flush_req  input  1  request to clear all FIFOs.
REQ-011 SHALL have port flush_done  output  1  one-cycle pulse when the flush completes.
REQ-012 SHALL have port FIFO  output  [NUM_FIFO][FIFO_SIZE][`NUM_SET_BITS+`NUM_TAG_BITS+64]  entries packed {index, tag, data}; feeds the dcache lookup stage directly.
REQ-013 SHALL have port entry_valid  output  [NUM_FIFO][FIFO_SIZE]  per-entry valid.
REQ-014 SHALL have port fifo_bound  output  NUM_FIFO  the FIFO is bound to a set index.

Function
REQ-015 SHALL drive all outputs from registers; an accepted fill is visible on FIFO/entry_valid in the following cycle (latency 1).
REQ-016 SHALL assert fill_ready = (state==IDLE) && !flush_req; a fill with fill_ready low SHALL be ignored.
REQ-017 SHALL store every valid entry of a bound FIFO with the bound set index, so FIFO[i][0] index field identifies the FIFO's set.
REQ-018 SHALL, on an accepted fill whose fill_index matches a bound FIFO and whose fill_tag matches a valid entry there, overwrite that entry's data in place with no shift.
REQ-019 SHALL, on an index match without a tag match, shift the FIFO (slot k to k+1), write the new entry into slot 0, set entry_valid[i][0], and drop slot FIFO_SIZE-1 when full.
REQ-020 SHALL, on no index match, bind the lowest-numbered unbound FIFO, clear its entries, and write the fill into slot 0.
REQ-021 SHALL, when no FIFO is free, evict the FIFO addressed by a round-robin victim pointer (clear all its entries, rebind), then increment the pointer modulo NUM_FIFO.
REQ-022 SHALL keep valid entries contiguous from slot 0; invalid entries SHALL output all-zero fields.
REQ-023 SHALL implement states IDLE and FLUSH: IDLE->FLUSH when flush_req is high; in FLUSH clear one FIFO per cycle (entries, valids, binding) via a flush counter 0..NUM_FIFO-1; FLUSH->IDLE after clearing FIFO NUM_FIFO-1, pulsing flush_done in that cycle.
REQ-024 SHALL give flush priority over a simultaneous fill_valid (fill not accepted); flush_req during FLUSH SHALL be ignored.
REQ-025 SHALL reset the victim pointer to 0 at flush completion.

Reset
REQ-026 SHALL, when reset is high at a clock edge, clear FIFO, entry_valid and fifo_bound to 0, set state IDLE, flush counter and victim pointer to 0, flush_done to 0.
REQ-027 SHALL let reset override any in-progress fill or flush; fill_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-028 SHALL take NUM_SET_BITS, NUM_TAG_BITS, NUM_FIFO, FIFO_SIZE, NUM_FIFO_BITS, NUM_FIFO_SIZE_BITS and a new DCACHE_FIFO_ENTRY_BITS from the shared sys_defs.vh definitions.
REQ-029 SHALL keep the state enum (IDLE, FLUSH) in the shared definitions file.
REQ-030 SHALL implement one FIFO's shift/update storage as sub-module dcache_fifo_line, instantiated NUM_FIFO times.

Verification
REQ-031 Reset, then fill idx=3 tag=0x12 data=0xAA -> next cycle fifo_bound[0]=1, FIFO[0][0]={3,0x12,0xAA}, entry_valid[0]=0001.
REQ-032 Five fills idx=3 tags 1..5 -> FIFO[0] holds tags 5,4,3,2 in slots 0..3, tag 1 dropped, entry_valid[0]=1111.
REQ-033 Refill idx=3 tag=3 data=0x55 -> slot holding tag 3 gets data 0x55, no other slot changes.
REQ-034 Fill idx 1,2,3,4 then idx=7 -> FIFO 0 evicted and rebound to 7 with one valid entry; next new index evicts FIFO 1.
REQ-035 flush_req and fill_valid in same cycle -> fill_ready=0, FLUSH lasts NUM_FIFO cycles, flush_done pulses once, all outputs 0 afterwards.
REQ-036 reset asserted mid-flush -> next cycle state IDLE, all outputs 0, fill_ready=1, no flush_done.
